// File: rtl/op_forward_stage_pkg.sv
// Shared types for the operand-preparation stage: register address and forwarding-select encoding.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package op_forward_stage_pkg;

  localparam int RF_ADD_W  = 5;
  localparam int FWD_SRC_W = 4;  // enough to name up to 16 forwarding sources

  typedef logic [RF_ADD_W-1:0] rf_add_t;

  localparam rf_add_t RF_X0 = '0;

  // Where an operand comes from; FWD_SRC carries the source index alongside
  typedef enum logic [1:0] {
    FWD_IMM  = 2'd0,
    FWD_ZERO = 2'd1,
    FWD_SRC  = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    fwd_sel_e             kind;
    logic [FWD_SRC_W-1:0] src;
  } fwd_sel_t;

  // A write-enabled destination that matches a source address
  function automatic logic addr_hit(input logic en, input rf_add_t rd, input rf_add_t rs);
    return en && (rd == rs);
  endfunction

endpackage

// File: rtl/op_forward_stage_op_select.sv
// Per-operand source selection (imm / x0 / forwarded / register file) with pending and hazard flags.
// Latency: purely combinational.
// Backpressure: none here; hazard_o feeds the stage stall.
module op_select
  import op_forward_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input  logic                     use_i,
  input  rf_add_t                  rs_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic [XLEN-1:0]          rf_i,
  input  logic [NFWD-1:0]          fwd_wr_i,
  input  logic [NFWD*RF_ADD_W-1:0] fwd_rd_i,
  input  logic [NFWD*XLEN-1:0]     fwd_val_i,
  input  logic [NFWD-1:0]          fwd_rdy_i,
  input  logic                     held_vld_i,
  input  logic                     held_late_i,
  input  rf_add_t                  held_rd_i,
  output logic [XLEN-1:0]          op_o,
  output logic                     pend_o,
  output logic                     hazard_o
);

  logic [NFWD-1:0]      rdy_hit;
  logic [NFWD-1:0]      wait_hit;
  logic                 rdy_any;
  logic                 wait_any;
  logic                 wait_old;
  logic [FWD_SRC_W-1:0] rdy_idx;
  logic [FWD_SRC_W-1:0] wait_idx;
  logic [XLEN-1:0]      src_val;
  logic                 waiting;
  logic                 held_hit;
  fwd_sel_t             sel;

  // Match this operand's address against every forwarding source, split by result readiness
  always_comb begin
    rdy_hit  = '0;
    wait_hit = '0;
    for (int j = 0; j < NFWD; j++) begin
      rdy_hit[j]  = addr_hit(fwd_wr_i[j], fwd_rd_i[j*RF_ADD_W +: RF_ADD_W], rs_i) &&  fwd_rdy_i[j];
      wait_hit[j] = addr_hit(fwd_wr_i[j], fwd_rd_i[j*RF_ADD_W +: RF_ADD_W], rs_i) && !fwd_rdy_i[j];
    end
  end

  // Youngest ready and youngest waiting match: scan oldest-first so the lowest index wins
  always_comb begin
    rdy_any  = 1'b0;
    rdy_idx  = '0;
    wait_any = 1'b0;
    wait_idx = '0;
    wait_old = 1'b0;
    for (int j = NFWD - 1; j >= 0; j--) begin
      if (rdy_hit[j]) begin
        rdy_any = 1'b1;
        rdy_idx = FWD_SRC_W'(j);
      end
      if (wait_hit[j]) begin
        wait_any = 1'b1;
        wait_idx = FWD_SRC_W'(j);
        wait_old = (j == NFWD - 1);
      end
    end
  end

  // Source decision, first match wins; a ready result always beats a waiting one
  always_comb begin
    sel     = '{kind: FWD_RF, src: '0};
    waiting = 1'b0;
    if (!use_i) begin
      sel.kind = FWD_IMM;
    end else if (rs_i == RF_X0) begin
      sel.kind = FWD_ZERO;
    end else if (rdy_any) begin
      sel = '{kind: FWD_SRC, src: rdy_idx};
    end else if (wait_any) begin
      sel     = '{kind: FWD_SRC, src: wait_idx};
      waiting = 1'b1;
    end
  end

  // Result of the selected forwarding source
  always_comb begin
    src_val = '0;
    for (int j = 0; j < NFWD; j++) begin
      if (sel.src == FWD_SRC_W'(j)) begin
        src_val = fwd_val_i[j*XLEN +: XLEN];
      end
    end
  end

  // Operand value; a waiting operand is parked at zero until its result arrives
  always_comb begin
    case (sel.kind)
      FWD_IMM:  op_o = imm_i;
      FWD_ZERO: op_o = '0;
      FWD_SRC:  op_o = waiting ? '0 : src_val;
      default:  op_o = rf_i;
    endcase
  end

  // Only the oldest source can be waited on in place; a younger one forces a bubble,
  // as does a late instruction sitting in the stage register that writes this operand
  always_comb begin
    held_hit = use_i && (rs_i != RF_X0) && held_vld_i && held_late_i && (held_rd_i == rs_i);
    pend_o   = waiting && wait_old;
    hazard_o = (waiting && !wait_old) || held_hit;
  end

endmodule

// File: rtl/op_forward_stage.sv
// Operand-preparation stage: selects/forwards up to three operands and registers them toward EX.
// Latency: 1 cycle ID->EX; s_stall_o is combinational.
// Backpressure: holds on s_stall_i (capturing late oldest-source results), inserts a bubble on hazards.
module op_forward_stage
  import op_forward_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int NFWD = 3,
  parameter int CW   = 32,
  parameter int CNTW = 16
) (
  input  logic                     s_clk_i,
  input  logic                     s_reset_i,
  input  logic                     s_stall_i,
  input  logic                     s_flush_i,
  output logic                     s_stall_o,
  input  logic                     s_idop_valid_i,
  input  logic [NSRC*RF_ADD_W-1:0] s_idop_rs_i,
  input  logic [NSRC-1:0]          s_idop_use_i,
  input  logic [NSRC*XLEN-1:0]     s_idop_imm_i,
  input  logic [NSRC*XLEN-1:0]     s_idop_rf_i,
  input  logic [RF_ADD_W-1:0]      s_idop_rd_i,
  input  logic                     s_idop_late_i,
  input  logic [CW-1:0]            s_idop_ctrl_i,
  input  logic [NFWD-1:0]          s_fwd_wr_i,
  input  logic [NFWD*RF_ADD_W-1:0] s_fwd_rd_i,
  input  logic [NFWD*XLEN-1:0]     s_fwd_val_i,
  input  logic [NFWD-1:0]          s_fwd_rdy_i,
  input  logic                     s_cnt_clr_i,
  output logic                     s_opex_valid_o,
  output logic [NSRC*XLEN-1:0]     s_opex_op_o,
  output logic [RF_ADD_W-1:0]      s_opex_rd_o,
  output logic [CW-1:0]            s_opex_ctrl_o,
  output logic [NSRC-1:0]          s_opex_pend_o,
  output logic [CNTW-1:0]          s_bubble_cnt_o
);

  localparam int OLD = NFWD - 1;

  logic                     vld_q,  vld_d;
  logic [NSRC*XLEN-1:0]     op_q,   op_d;
  rf_add_t                  rd_q,   rd_d;
  logic [CW-1:0]            ctrl_q, ctrl_d;
  logic [NSRC-1:0]          pend_q, pend_d;
  logic [NSRC*RF_ADD_W-1:0] rs_q,   rs_d;
  logic                     late_q, late_d;
  logic [CNTW-1:0]          cnt_q,  cnt_d;

  logic [NSRC*XLEN-1:0]     sel_op;
  logic [NSRC-1:0]          sel_pend;
  logic [NSRC-1:0]          sel_hz;
  logic                     hazard;
  logic                     bubble;
  logic [NSRC*XLEN-1:0]     cap_op;
  logic [NSRC-1:0]          cap_pend;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    op_select #(
      .XLEN (XLEN),
      .NFWD (NFWD)
    ) u_sel (
      .use_i       (s_idop_use_i[k]),
      .rs_i        (s_idop_rs_i[k*RF_ADD_W +: RF_ADD_W]),
      .imm_i       (s_idop_imm_i[k*XLEN +: XLEN]),
      .rf_i        (s_idop_rf_i[k*XLEN +: XLEN]),
      .fwd_wr_i    (s_fwd_wr_i),
      .fwd_rd_i    (s_fwd_rd_i),
      .fwd_val_i   (s_fwd_val_i),
      .fwd_rdy_i   (s_fwd_rdy_i),
      .held_vld_i  (vld_q),
      .held_late_i (late_q),
      .held_rd_i   (rd_q),
      .op_o        (sel_op[k*XLEN +: XLEN]),
      .pend_o      (sel_pend[k]),
      .hazard_o    (sel_hz[k])
    );
  end

  // Any operand of a valid incoming instruction can raise the hazard; a bubble is only
  // actually inserted when the stage is neither flushed nor held
  always_comb begin
    hazard    = s_idop_valid_i && (|sel_hz);
    bubble    = hazard && !s_flush_i && !s_stall_i;
    s_stall_o = s_stall_i || (hazard && !s_flush_i);
  end

  // Oldest-source result landing on a held pending operand
  always_comb begin
    cap_op   = op_q;
    cap_pend = pend_q;
    for (int k = 0; k < NSRC; k++) begin
      if (pend_q[k] && addr_hit(s_fwd_rdy_i[OLD], s_fwd_rd_i[OLD*RF_ADD_W +: RF_ADD_W],
                                rs_q[k*RF_ADD_W +: RF_ADD_W])) begin
        cap_op[k*XLEN +: XLEN] = s_fwd_val_i[OLD*XLEN +: XLEN];
        cap_pend[k]            = 1'b0;
      end
    end
  end

  // Stage register next state: flush, then hold-with-capture, then bubble, then load
  always_comb begin
    vld_d  = vld_q;
    op_d   = op_q;
    rd_d   = rd_q;
    ctrl_d = ctrl_q;
    pend_d = pend_q;
    rs_d   = rs_q;
    late_d = late_q;
    if (s_flush_i || (!s_stall_i && hazard)) begin
      vld_d  = 1'b0;
      op_d   = '0;
      rd_d   = '0;
      ctrl_d = '0;
      pend_d = '0;
      rs_d   = '0;
      late_d = 1'b0;
    end else if (s_stall_i) begin
      op_d   = cap_op;
      pend_d = cap_pend;
    end else begin
      vld_d  = s_idop_valid_i;
      op_d   = sel_op;
      rd_d   = s_idop_rd_i;
      ctrl_d = s_idop_ctrl_i;
      pend_d = sel_pend & {NSRC{s_idop_valid_i}};
      rs_d   = s_idop_rs_i;
      late_d = s_idop_late_i;
    end
  end

  // Saturating bubble counter; clear beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (s_cnt_clr_i) begin
      cnt_d = '0;
    end else if (bubble && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      vld_q  <= 1'b0;
      op_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
      pend_q <= '0;
      rs_q   <= '0;
      late_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      op_q   <= op_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
      pend_q <= pend_d;
      rs_q   <= rs_d;
      late_q <= late_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s_opex_valid_o = vld_q;
  assign s_opex_op_o    = op_q;
  assign s_opex_rd_o    = rd_q;
  assign s_opex_ctrl_o  = ctrl_q;
  assign s_opex_pend_o  = pend_q;
  assign s_bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_op_forward_stage.sv
// Bench for op_forward_stage: vector table, directed corner sequences and random traffic vs a model.
// Latency: outputs checked 1 ns after each rising edge, s_stall_o on the falling edge.
// Backpressure: stall/flush driven by the bench.
module tb_op_forward_stage;
  localparam int XLEN = 32, NSRC = 2, NFWD = 3, CW = 32, CNTW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst, stall, flush, stall_o, idv, late, cclr;
  logic [NSRC-1:0][4:0]       rs;
  logic [NSRC-1:0]            opuse;
  logic [NSRC-1:0][XLEN-1:0]  imm, rf;
  logic [4:0]                 rd;
  logic [CW-1:0]              ctrl;
  logic [NFWD-1:0]            fwr, frdy;
  logic [NFWD-1:0][4:0]       frd;
  logic [NFWD-1:0][XLEN-1:0]  fval;
  logic                       ovld;
  logic [NSRC-1:0][XLEN-1:0]  oop;
  logic [4:0]                 ord;
  logic [CW-1:0]              octrl;
  logic [NSRC-1:0]            opend;
  logic [CNTW-1:0]            ocnt;

  op_forward_stage #(.XLEN(XLEN), .NSRC(NSRC), .NFWD(NFWD), .CW(CW), .CNTW(CNTW)) dut (
    .s_clk_i(clk), .s_reset_i(rst), .s_stall_i(stall), .s_flush_i(flush), .s_stall_o(stall_o),
    .s_idop_valid_i(idv), .s_idop_rs_i(rs), .s_idop_use_i(opuse), .s_idop_imm_i(imm),
    .s_idop_rf_i(rf), .s_idop_rd_i(rd), .s_idop_late_i(late), .s_idop_ctrl_i(ctrl),
    .s_fwd_wr_i(fwr), .s_fwd_rd_i(frd), .s_fwd_val_i(fval), .s_fwd_rdy_i(frdy),
    .s_cnt_clr_i(cclr), .s_opex_valid_o(ovld), .s_opex_op_o(oop), .s_opex_rd_o(ord),
    .s_opex_ctrl_o(octrl), .s_opex_pend_o(opend), .s_bubble_cnt_o(ocnt)
  );

  int n_chk = 0, n_err = 0;
  logic stall_smp;

  // Reference state: what the stage register should hold
  typedef struct packed {
    logic                      vld;
    logic [NSRC-1:0][XLEN-1:0] op;
    logic [4:0]                rd;
    logic [CW-1:0]             ctrl;
    logic [NSRC-1:0]           pend;
    logic [NSRC-1:0][4:0]      rs;
    logic                      late;
    logic [CNTW-1:0]           cnt;
  } mst_t;
  mst_t m, mn;
  logic exp_stall;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Next state from the current inputs, following the selection/hazard/update rules directly
  function automatic void model_next();
    logic hz;
    logic [NSRC-1:0][XLEN-1:0] pop;
    logic [NSRC-1:0] ppend;
    hz = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      int rj, wj;
      rj = -1; wj = -1;
      pop[k] = rf[k]; ppend[k] = 1'b0;
      if (!opuse[k]) pop[k] = imm[k];
      else if (rs[k] == 0) pop[k] = '0;
      else begin
        for (int j = 0; j < NFWD; j++)
          if (fwr[j] && frd[j] == rs[k]) begin
            if (frdy[j] && rj < 0) rj = j;
            if (!frdy[j] && wj < 0) wj = j;
          end
        if (rj >= 0) pop[k] = fval[rj];
        else if (wj == NFWD - 1) begin ppend[k] = 1'b1; pop[k] = '0; end
        else if (wj >= 0) begin hz = 1'b1; pop[k] = '0; end
        if (m.vld && m.late && m.rd == rs[k]) hz = 1'b1;
      end
    end
    hz = hz & idv;
    exp_stall = stall | (hz & ~flush);
    mn = m;
    if (flush) begin
      mn = '0; mn.cnt = m.cnt;
    end else if (stall) begin
      for (int k = 0; k < NSRC; k++)
        if (m.pend[k] && frdy[NFWD-1] && frd[NFWD-1] == m.rs[k]) begin
          mn.op[k] = fval[NFWD-1]; mn.pend[k] = 1'b0;
        end
    end else if (hz) begin
      mn = '0;
      mn.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
    end else begin
      mn.vld = idv; mn.op = pop; mn.rd = rd; mn.ctrl = ctrl;
      mn.pend = ppend & {NSRC{idv}}; mn.rs = rs; mn.late = late;
    end
    if (cclr) mn.cnt = '0;
  endfunction

  task automatic step();
    @(negedge clk);
    model_next();
    stall_smp = stall_o;
    check("stall_o", stall_o, exp_stall);
    @(posedge clk);
    m = mn;
    #1;
    check("model", {ovld, oop, ord, octrl, opend, ocnt}, {m.vld, m.op, m.rd, m.ctrl, m.pend, m.cnt});
  endtask

  task automatic set_idle();
    stall = 0; flush = 0; idv = 0; late = 0; cclr = 0; rs = '0; opuse = '0; imm = '0; rf = '0;
    rd = '0; ctrl = '0; fwr = '0; frdy = '0; frd = '0; fval = '0;
  endtask

  // Asynchronous reset between edges; released before the next falling edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check("reset_state", {ovld, oop, ord, octrl, opend, ocnt}, 128'd0);
    m = '0;
    rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  opuse;
    logic [4:0]  rs0, rs1;
    logic [31:0] rf0, rf1, imm0, imm1;
    logic [2:0]  wr, rdy;
    logic [4:0]  fr0, fr1, fr2;
    logic [31:0] fv0, fv1, fv2;
    logic        e_vld, e_stall;
    logic [31:0] e0, e1;
    logic [1:0]  e_pend;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{"nodep",   2'b11, 3, 4, 32'h11, 32'h22, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 32'h11, 32'h22, 2'b00};
    tbl[1] = '{"prio",    2'b11, 3, 4, 32'h11, 32'h22, 0, 0, 3'b101, 3'b111, 3, 0, 3, 32'hA, 0, 32'hB, 1, 0, 32'hA, 32'h22, 2'b00};
    tbl[2] = '{"imm",     2'b00, 3, 4, 32'h11, 32'h22, 32'h100, 32'h200, 3'b111, 3'b111, 3, 4, 3, 32'hA, 32'hC, 32'hB, 1, 0, 32'h100, 32'h200, 2'b00};
    tbl[3] = '{"x0",      2'b11, 0, 4, 32'h11, 32'h22, 0, 0, 3'b001, 3'b001, 0, 0, 0, 32'hDEAD, 0, 0, 1, 0, 32'h0, 32'h22, 2'b00};
    tbl[4] = '{"rdybeat", 2'b11, 3, 4, 32'h11, 32'h22, 0, 0, 3'b011, 3'b010, 3, 3, 0, 32'h1, 32'h77, 0, 1, 0, 32'h77, 32'h22, 2'b00};
    tbl[5] = '{"pendold", 2'b11, 7, 4, 32'h11, 32'h22, 0, 0, 3'b100, 3'b000, 0, 0, 7, 0, 0, 0, 1, 0, 32'h0, 32'h22, 2'b01};
    tbl[6] = '{"oldrdy",  2'b11, 3, 4, 32'h11, 32'h22, 0, 0, 3'b100, 3'b100, 0, 0, 4, 0, 0, 32'h99, 1, 0, 32'h11, 32'h99, 2'b00};
    tbl[7] = '{"nowr",    2'b11, 3, 4, 32'h11, 32'h22, 0, 0, 3'b000, 3'b111, 3, 4, 3, 32'hA, 32'hC, 32'hB, 1, 0, 32'h11, 32'h22, 2'b00};
    tbl[8] = '{"hzyoung", 2'b11, 3, 4, 32'h11, 32'h22, 0, 0, 3'b001, 3'b000, 3, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 2'b00};
    tbl[9] = '{"hzmid",   2'b11, 7, 4, 32'h11, 32'h22, 0, 0, 3'b110, 3'b000, 0, 4, 7, 0, 0, 0, 0, 1, 32'h0, 32'h0, 2'b00};

    rst = 1'b0; set_idle();
    @(posedge clk); #1;
    do_reset();

    // Vector table, each row one instruction from a non-late predecessor
    for (int i = 0; i < 10; i++) begin
      set_idle();
      idv = 1; rd = 5'd1; ctrl = 32'(i);
      opuse = tbl[i].opuse; rs[0] = tbl[i].rs0; rs[1] = tbl[i].rs1;
      rf[0] = tbl[i].rf0; rf[1] = tbl[i].rf1; imm[0] = tbl[i].imm0; imm[1] = tbl[i].imm1;
      fwr = tbl[i].wr; frdy = tbl[i].rdy; frd[0] = tbl[i].fr0; frd[1] = tbl[i].fr1; frd[2] = tbl[i].fr2;
      fval[0] = tbl[i].fv0; fval[1] = tbl[i].fv1; fval[2] = tbl[i].fv2;
      step();
      check({tbl[i].name, "_stall"}, stall_smp, tbl[i].e_stall);
      check({tbl[i].name, "_vld"},   ovld,      tbl[i].e_vld);
      check({tbl[i].name, "_op"},    {oop[1], oop[0]}, {tbl[i].e1, tbl[i].e0});
      check({tbl[i].name, "_pend"},  opend,     tbl[i].e_pend);
    end

    // Load-use bubble then reload
    do_reset(); set_idle();
    idv = 1; opuse = 2'b11; rs[0] = 1; rs[1] = 2; rf[0] = 32'h11; rf[1] = 32'h22; rd = 5; late = 1; ctrl = 32'hC0FFEE;
    step();
    check("lu_load_vld", ovld, 1'b1);
    rs[0] = 5; rf[0] = 32'h33; rf[1] = 32'h44; rd = 6; late = 0;
    step();
    check("lu_stall", stall_smp, 1'b1);
    check("lu_bubble", ovld, 1'b0);
    check("lu_cnt", ocnt, 16'd1);
    step();
    check("lu_after_stall", stall_smp, 1'b0);
    check("lu_after_vld", ovld, 1'b1);
    check("lu_after_op", {oop[0], ord}, {32'h33, 5'd6});

    // Capture of the oldest source while held
    do_reset(); set_idle();
    idv = 1; opuse = 2'b11; rs[0] = 7; rs[1] = 2; rf[0] = 32'h11; rf[1] = 32'h22; rd = 9;
    fwr = 3'b100; frd[2] = 7;
    step();
    check("cap_pend0", opend, 2'b01);
    stall = 1;
    step();
    check("cap_pend1", opend, 2'b01);
    frdy[2] = 1; fval[2] = 32'h55;
    step();
    check("cap_op", {ovld, oop[0], opend}, {1'b1, 32'h55, 2'b00});

    // Flush during stall and hazard, then flush against a hazard alone
    do_reset(); set_idle();
    idv = 1; opuse = 2'b11; rs[0] = 1; rs[1] = 7; rd = 5; late = 1; fwr = 3'b100; frd[2] = 7;
    step();
    check("fl_setup_pend", opend, 2'b10);
    rs[0] = 5; rs[1] = 2; fwr = 0; late = 0; stall = 1; flush = 1;
    step();
    check("fl_stall_o", stall_smp, 1'b1);
    check("fl_state", {ovld, opend, ocnt}, {1'b0, 2'b00, 16'd0});
    stall = 0; flush = 0; rs[0] = 1; rd = 5; late = 1;
    step();
    rs[0] = 5; flush = 1;
    step();
    check("fl_hz_stall_o", stall_smp, 1'b0);
    check("fl_hz_cnt", {ovld, ocnt}, {1'b0, 16'd0});

    // Reset while held with a pending operand
    set_idle(); idv = 1; opuse = 2'b01; rs[0] = 7; fwr = 3'b100; frd[2] = 7; ctrl = 32'h1234;
    step();
    stall = 1;
    step();
    do_reset();

    // Counter: clear priority and saturation, hazard every cycle via a waiting young source
    set_idle(); idv = 1; opuse = 2'b01; rs[0] = 3; fwr = 3'b001; frd[0] = 3;
    repeat (3) step();
    check("cnt_three", ocnt, 16'd3);
    cclr = 1;
    step();
    check("cnt_clr_over_inc", ocnt, 16'd0);
    cclr = 0;
    repeat (65535) step();
    check("cnt_max", ocnt, 16'hFFFF);
    step();
    check("cnt_saturate", ocnt, 16'hFFFF);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idv   = ($urandom_range(0, 3) != 0);
      late  = ($urandom_range(0, 2) == 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 15) == 0);
      cclr  = ($urandom_range(0, 63) == 0);
      opuse = 2'($urandom);
      rd    = 5'($urandom_range(0, 7));
      ctrl  = $urandom;
      for (int k = 0; k < NSRC; k++) begin
        rs[k] = 5'($urandom_range(0, 7)); imm[k] = $urandom; rf[k] = $urandom;
      end
      fwr = 3'($urandom); frdy = 3'($urandom);
      for (int j = 0; j < NFWD; j++) begin
        frd[j] = 5'($urandom_range(0, 7)); fval[j] = $urandom;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
